relay_pick_sequencer: RTL and testbench

- Upstream driver for a bank of relay models: accepts a one-word operate request, drives the selected relay's `pick` line, and checks the relay's `pulled` feedback.
- All timing is measured in the 1 ms `tick_ms` strobe from the timer block, not in clock cycles.
- Provides the ordered pick, hold, drop and dwell sequence, with fault timeouts, that the typewriter and tape-punch solenoid logic needs.

---
 rtl/relay_pick_sequencer_pkg.sv | 21 ++
 rtl/relay_pick_sequencer_if.sv | 32 +++
 rtl/relay_pick_sequencer_ms_counter.sv | 41 ++++
 rtl/relay_pick_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_relay_pick_sequencer.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/relay_pick_sequencer_pkg.sv
// relay_pkg: shared types and defaults for the relay pick sequencer.
//   seq_state_t - sequencer FSM states
//   DEF_*       - default parameter values (times in ms)
//   sel_width() - width of the relay select field
package relay_pkg;

   typedef enum logic [2:0] {IDLE, PULL, HOLD, DROP, DWELL} seq_state_t;

   localparam int unsigned DEF_N_RELAYS   = 4;
   localparam int unsigned DEF_HOLD_MS    = 10;
   localparam int unsigned DEF_DWELL_MS   = 20;
   localparam int unsigned DEF_TIMEOUT_MS = 100;
   localparam int unsigned DEF_CNT_W      = 8;

   // Wide enough to encode the value n itself, so an out-of-range index
   // (sel >= n) is always representable and can be rejected.
   function automatic int unsigned sel_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/relay_pick_sequencer_if.sv
// relay_pick_sequencer_if: operate-request handshake plus relay pick/pulled bus.
//   req, sel             - operate request and relay index (requester -> sequencer)
//   ready, done, fault   - status (sequencer -> requester)
//   pick                 - one-hot pick drive (sequencer -> relays)
//   pulled               - relay pulled-in feedback (relays -> sequencer)
// Modports: master = requester/relay side, slave = sequencer.
interface relay_pick_sequencer_if #(
   parameter int unsigned N_RELAYS = 4
);
   import relay_pkg::*;

   localparam int unsigned SEL_W = sel_width(N_RELAYS);

   logic                req;
   logic [SEL_W-1:0]    sel;
   logic                ready;
   logic                done;
   logic                fault;
   logic [N_RELAYS-1:0] pick;
   logic [N_RELAYS-1:0] pulled;

   modport master (
      output req, sel, pulled,
      input  ready, done, fault, pick
   );

   modport slave (
      input  req, sel, pulled,
      output ready, done, fault, pick
   );

endinterface

// File: rtl/relay_pick_sequencer_ms_counter.sv
// ms_counter: millisecond up-counter advanced by tick_ms, saturating at all-ones.
//   clk, rst  - clock, asynchronous active-low reset
//   clr       - synchronous clear (has priority over tick_ms)
//   tick_ms   - 1 ms strobe; count advances by one when set
//   limit     - compare value
//   reached   - count >= limit
module ms_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             tick_ms,
   input  logic [CNT_W-1:0] limit,
   output logic             reached
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (tick_ms && (count_q != CntMax)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign reached = (count_q >= limit);

endmodule

// File: rtl/relay_pick_sequencer.sv
// relay_pick_sequencer: drives one relay through pick, hold, drop and dwell, checking
// the pulled feedback against ms timeouts.
//   clk, rst  - system clock, asynchronous active-low reset
//   tick_ms   - 1 ms strobe from the timer block
//   bus       - relay_pick_sequencer_if.slave (req/sel/ready/done/fault/pick/pulled)
//   fault_cnt - saturating timeout count; present only with
//               RELAY_PICK_SEQ_FAULT_CNT_EN defined
// All outputs are registered.
module relay_pick_sequencer
   import relay_pkg::*;
#(
   parameter int unsigned N_RELAYS   = DEF_N_RELAYS,
   parameter int unsigned HOLD_MS    = DEF_HOLD_MS,
   parameter int unsigned DWELL_MS   = DEF_DWELL_MS,
   parameter int unsigned TIMEOUT_MS = DEF_TIMEOUT_MS,
   parameter int unsigned CNT_W      = DEF_CNT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick_ms,
   relay_pick_sequencer_if.slave bus
`ifdef RELAY_PICK_SEQ_FAULT_CNT_EN
   ,
   output logic [7:0]            fault_cnt
`endif
);

   localparam int unsigned SEL_W = sel_width(N_RELAYS);

   localparam logic [CNT_W-1:0] HoldLim    = CNT_W'(HOLD_MS);
   localparam logic [CNT_W-1:0] DwellLim   = CNT_W'(DWELL_MS);
   localparam logic [CNT_W-1:0] TimeoutLim = CNT_W'(TIMEOUT_MS);

   seq_state_t          state_q, state_d;
   logic [N_RELAYS-1:0] sel_oh_q, sel_oh_d;
   logic [N_RELAYS-1:0] pick_q, pick_d;
   logic                ready_q, ready_d;
   logic                done_q, done_d;
   logic                fault_q, fault_d;
   logic [N_RELAYS-1:0] req_oh;
   logic                pulled_sel;
   logic                cnt_clr;
   logic [CNT_W-1:0]    limit;
   logic                reached;

   always_comb begin
      req_oh = '0;
      for (int unsigned i = 0; i < N_RELAYS; i++) begin
         req_oh[i] = (bus.sel == SEL_W'(i));
      end
   end

   // Feedback of the captured relay only; other pulled bits are don't-care.
   assign pulled_sel = |(bus.pulled & sel_oh_q);

   ms_counter #(
      .CNT_W (CNT_W)
   ) u_ms_counter (
      .clk     (clk),
      .rst     (rst),
      .clr     (cnt_clr),
      .tick_ms (tick_ms),
      .limit   (limit),
      .reached (reached)
   );

   always_comb begin
      state_d  = state_q;
      sel_oh_d = sel_oh_q;
      pick_d   = pick_q;
      ready_d  = ready_q;
      done_d   = 1'b0;
      fault_d  = fault_q;
      cnt_clr  = 1'b0;
      limit    = TimeoutLim;
      unique case (state_q)
         IDLE: begin
            cnt_clr = 1'b1;
            if (bus.req) begin
               if (bus.sel >= SEL_W'(N_RELAYS)) begin
                  fault_d = 1'b1;
               end else begin
                  sel_oh_d = req_oh;
                  pick_d   = req_oh;
                  ready_d  = 1'b0;
                  fault_d  = 1'b0;
                  state_d  = PULL;
               end
            end
         end
         PULL: begin
            limit = TimeoutLim;
            // pulled is tested first so it wins over a same-cycle timeout
            if (pulled_sel) begin
               cnt_clr = 1'b1;
               state_d = HOLD;
            end else if (reached) begin
               pick_d  = '0;
               fault_d = 1'b1;
               cnt_clr = 1'b1;
               state_d = DWELL;
            end
         end
         HOLD: begin
            limit = HoldLim;
            if (reached) begin
               pick_d  = '0;
               cnt_clr = 1'b1;
               state_d = DROP;
            end
         end
         DROP: begin
            limit = TimeoutLim;
            if (!pulled_sel) begin
               cnt_clr = 1'b1;
               state_d = DWELL;
            end else if (reached) begin
               fault_d = 1'b1;
               cnt_clr = 1'b1;
               state_d = DWELL;
            end
         end
         DWELL: begin
            limit = DwellLim;
            if (reached) begin
               ready_d = 1'b1;
               done_d  = !fault_q;
               state_d = IDLE;
            end
         end
         default: begin
            pick_d  = '0;
            ready_d = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         sel_oh_q <= '0;
         pick_q   <= '0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_oh_q <= sel_oh_d;
         pick_q   <= pick_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
         fault_q  <= fault_d;
      end
   end

   assign bus.pick  = pick_q;
   assign bus.ready = ready_q;
   assign bus.done  = done_q;
   assign bus.fault = fault_q;

`ifdef RELAY_PICK_SEQ_FAULT_CNT_EN
   logic       timeout_ev;
   logic [7:0] fault_cnt_q;

   assign timeout_ev = reached && (((state_q == PULL) && !pulled_sel) ||
                                   ((state_q == DROP) && pulled_sel));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fault_cnt_q <= '0;
      end else if (timeout_ev && (fault_cnt_q != 8'hFF)) begin
         fault_cnt_q <= fault_cnt_q + 8'd1;
      end
   end

   assign fault_cnt = fault_cnt_q;
`endif

endmodule

// File: tb/tb_relay_pick_sequencer.sv
// tb_relay_pick_sequencer: directed bench for relay_pick_sequencer with a ms timer and a
// relay model (pulled rises on the 3rd ms tick with pick high, falls on the 2nd tick after
// pick drops; modes suppress pull-in or release).
module tb_relay_pick_sequencer;
   import relay_pkg::*;

   localparam int unsigned N          = 4;
   localparam int unsigned SEL_W      = sel_width(N);
   localparam int unsigned CLK_PER_MS = 107;  // ~1 ms at a 9.3 us clock

   localparam int unsigned REL_NORMAL     = 0;
   localparam int unsigned REL_NO_PULL    = 1;
   localparam int unsigned REL_NO_RELEASE = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic tick_ms = 1'b0;

   int unsigned pass_cnt  = 0;
   int unsigned fail_cnt  = 0;
   int unsigned check_cnt = 0;

   int unsigned div_q    = 0;
   int unsigned ms_now   = 0;
   int unsigned rel_mode = REL_NORMAL;
   int unsigned rel_cnt [N] = '{default: 0};
   logic [N-1:0] pulled_m = '0;
   int unsigned done_cnt = 0;
   logic pick3_seen = 1'b0;
   logic multi_hot  = 1'b0;

   relay_pick_sequencer_if #(.N_RELAYS(N)) bus ();

   assign bus.pulled = pulled_m;

`ifdef RELAY_PICK_SEQ_FAULT_CNT_EN
   logic [7:0] fault_cnt;
`endif

   relay_pick_sequencer #(
      .N_RELAYS   (N),
      .HOLD_MS    (10),
      .DWELL_MS   (20),
      .TIMEOUT_MS (100),
      .CNT_W      (8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .tick_ms (tick_ms),
      .bus     (bus)
`ifdef RELAY_PICK_SEQ_FAULT_CNT_EN
      ,
      .fault_cnt (fault_cnt)
`endif
   );

   always #5 clk = ~clk;

   // ms timer
   always @(posedge clk) begin
      if (div_q == CLK_PER_MS - 1) begin
         div_q   <= 0;
         tick_ms <= 1'b1;
      end else begin
         div_q   <= div_q + 1;
         tick_ms <= 1'b0;
      end
      if (tick_ms) ms_now <= ms_now + 1;
   end

   // relay model
   always @(posedge clk) begin
      if (tick_ms) begin
         for (int i = 0; i < N; i++) begin
            if (bus.pick[i] && !pulled_m[i]) begin
               if (rel_mode != REL_NO_PULL) begin
                  if (rel_cnt[i] == 2) begin
                     pulled_m[i] <= 1'b1;
                     rel_cnt[i]  <= 0;
                  end else begin
                     rel_cnt[i] <= rel_cnt[i] + 1;
                  end
               end
            end else if (!bus.pick[i] && pulled_m[i]) begin
               if (rel_mode != REL_NO_RELEASE) begin
                  if (rel_cnt[i] == 1) begin
                     pulled_m[i] <= 1'b0;
                     rel_cnt[i]  <= 0;
                  end else begin
                     rel_cnt[i] <= rel_cnt[i] + 1;
                  end
               end
            end else begin
               rel_cnt[i] <= 0;
            end
         end
      end
   end

   // monitors
   always @(posedge clk) begin
      if (bus.done) done_cnt <= done_cnt + 1;
      if (bus.pick[3]) pick3_seen <= 1'b1;
      if ($countones(bus.pick) > 1) multi_hot <= 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input int unsigned val, input int unsigned lo,
                          input int unsigned hi);
      check_cnt++;
      assert (val >= lo && val <= hi) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, val, lo, hi);
      end
   endtask

   task automatic issue(input logic [SEL_W-1:0] s);
      bus.req = 1'b1;
      bus.sel = s;
      @(negedge clk);
      bus.req = 1'b0;
      bus.sel = '0;
   endtask

   task automatic wait_ms(input int unsigned n);
      int unsigned target;
      target = ms_now + n;
      while (ms_now < target) @(negedge clk);
   endtask

   initial begin
      repeat (95000) @(posedge clk);
      $display("FAIL watchdog: simulation did not finish within cycle budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned t0, t1, n, dcnt;
      bus.req = 1'b0;
      bus.sel = '0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_pick", 32'(bus.pick), 32'h0);
      chk("rst_ready", 32'(bus.ready), 32'h1);
      chk("rst_done", 32'(bus.done), 32'h0);
      chk("rst_fault", 32'(bus.fault), 32'h0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // clean sequence on relay 2
      issue(3'd2);
      t0 = ms_now;
      chk("t1_pick_rise", 32'(bus.pick), 32'h4);
      chk("t1_ready_low", 32'(bus.ready), 32'h0);
      n = 0;
      while (!pulled_m[2] && n < 6 * CLK_PER_MS) begin @(negedge clk); n++; end
      chk_rng("t1_pulled_ms", ms_now - t0, 2, 4);
      chk("t1_pick_hold", 32'(bus.pick), 32'h4);
      n = 0;
      while (bus.pick != 4'b0 && n < 15 * CLK_PER_MS) begin @(negedge clk); n++; end
      chk_rng("t1_drop_ms", ms_now - t0, 12, 14);
      n = 0;
      while (!bus.done && n < 30 * CLK_PER_MS) begin @(negedge clk); n++; end
      chk("t1_done", 32'(bus.done), 32'h1);
      chk_rng("t1_done_ms", ms_now - t0, 34, 36);
      chk("t1_fault", 32'(bus.fault), 32'h0);
      @(negedge clk);
      chk("t1_done_pulse", 32'(bus.done), 32'h0);
      chk("t1_ready", 32'(bus.ready), 32'h1);

      // relay 1 never pulls in
      rel_mode = REL_NO_PULL;
      dcnt = done_cnt;
      issue(3'd1);
      t0 = ms_now;
      chk("t2_pick_rise", 32'(bus.pick), 32'h2);
      wait_ms(50);
      chk("t2_pick_mid", 32'(bus.pick), 32'h2);
      n = 0;
      while (bus.pick != 4'b0 && n < 60 * CLK_PER_MS) begin @(negedge clk); n++; end
      t1 = ms_now;
      chk_rng("t2_timeout_ms", t1 - t0, 99, 101);
      chk("t2_fault", 32'(bus.fault), 32'h1);
      chk("t2_ready_low", 32'(bus.ready), 32'h0);
      n = 0;
      while (!bus.ready && n < 25 * CLK_PER_MS) begin @(negedge clk); n++; end
      chk("t2_ready", 32'(bus.ready), 32'h1);
      chk_rng("t2_dwell_ms", ms_now - t1, 19, 21);
      chk("t2_no_done", done_cnt, dcnt);
`ifdef RELAY_PICK_SEQ_FAULT_CNT_EN
      chk("t2_fault_cnt", 32'(fault_cnt), 32'h1);
`endif
      rel_mode = REL_NORMAL;

      // clean sequence clears fault; req while busy is ignored
      dcnt = done_cnt;
      issue(3'd2);
      t0 = ms_now;
      chk("t3_fault_clr", 32'(bus.fault), 32'h0);
      wait_ms(6);
      issue(3'd3);
      chk("t3_pick_busy", 32'(bus.pick), 32'h4);
      n = 0;
      while (!bus.done && n < 35 * CLK_PER_MS) begin @(negedge clk); n++; end
      chk("t3_done", 32'(bus.done), 32'h1);
      chk_rng("t3_done_ms", ms_now - t0, 34, 36);
      wait_ms(5);
      chk("t3_one_done", done_cnt, dcnt + 1);
      chk("t3_ready", 32'(bus.ready), 32'h1);
      chk("t3_pick_idle", 32'(bus.pick), 32'h0);
`ifdef RELAY_PICK_SEQ_FAULT_CNT_EN
      chk("t3_fault_cnt", 32'(fault_cnt), 32'h1);
`endif

      // out-of-range select
      issue(3'd4);
      chk("t5_fault", 32'(bus.fault), 32'h1);
      chk("t5_pick", 32'(bus.pick), 32'h0);
      chk("t5_ready", 32'(bus.ready), 32'h1);
      repeat (3) @(negedge clk);
      chk("t5_pick_stay", 32'(bus.pick), 32'h0);

      // relay 0 never releases
      rel_mode = REL_NO_RELEASE;
      dcnt = done_cnt;
      issue(3'd0);
      t0 = ms_now;
      chk("t4_fault_clr", 32'(bus.fault), 32'h0);
      chk("t4_pick_rise", 32'(bus.pick), 32'h1);
      n = 0;
      while (bus.pick != 4'b0 && n < 20 * CLK_PER_MS) begin @(negedge clk); n++; end
      t1 = ms_now;
      chk_rng("t4_drop_ms", t1 - t0, 12, 14);
      n = 0;
      while (!bus.fault && n < 110 * CLK_PER_MS) begin @(negedge clk); n++; end
      chk("t4_fault", 32'(bus.fault), 32'h1);
      chk_rng("t4_timeout_ms", ms_now - t1, 99, 101);
      n = 0;
      while (!bus.ready && n < 25 * CLK_PER_MS) begin @(negedge clk); n++; end
      chk("t4_ready", 32'(bus.ready), 32'h1);
      chk("t4_no_done", done_cnt, dcnt);
`ifdef RELAY_PICK_SEQ_FAULT_CNT_EN
      chk("t4_fault_cnt", 32'(fault_cnt), 32'h2);
`endif
      rel_mode = REL_NORMAL;
      wait_ms(4);

      // reset mid-HOLD: pick drops without a clock edge
      dcnt = done_cnt;
      issue(3'd2);
      wait_ms(6);
      chk("t6_pick_hold", 32'(bus.pick), 32'h4);
      #2 rst = 1'b0;
      #1 chk("t6_pick_async", 32'(bus.pick), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("t6_ready", 32'(bus.ready), 32'h1);
      chk("t6_done", 32'(bus.done), 32'h0);
      chk("t6_fault", 32'(bus.fault), 32'h0);
      wait_ms(25);
      chk("t6_no_done", done_cnt, dcnt);

      chk("pick3_never", 32'(pick3_seen), 32'h0);
      chk("pick_onehot", 32'(multi_hot), 32'h0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
